// File: rtl/auth_pkg.sv
// Shared constants for the authentication responder: message codes, error
// codes, back-end command encoding, FSM state codes and header field layout.
package auth_pkg;

   // Request message types
   localparam logic [7:0] MT_GET_DIGESTS = 8'h81;
   localparam logic [7:0] MT_GET_CERT    = 8'h82;
   localparam logic [7:0] MT_CHALLENGE   = 8'h83;

   // Response message types
   localparam logic [7:0] MT_DIGESTS     = 8'h01;
   localparam logic [7:0] MT_CERTIFICATE = 8'h02;
   localparam logic [7:0] MT_CHAL_AUTH   = 8'h03;
   localparam logic [7:0] MT_ERROR       = 8'h7F;
   localparam logic [7:0] MT_RESP_OFFSET = 8'h80;

   // Error codes carried in Param1 of an ERROR response
   localparam logic [7:0] ERR_INVALID     = 8'h01;
   localparam logic [7:0] ERR_UNSUP_PROTO = 8'h02;
   localparam logic [7:0] ERR_BUSY        = 8'h03;
   localparam logic [7:0] ERR_UNSPEC      = 8'h04;

   // Back-end command encoding
   localparam logic [1:0] BE_NONE    = 2'd0;
   localparam logic [1:0] BE_DIGESTS = 2'd1;
   localparam logic [1:0] BE_CERT    = 2'd2;
   localparam logic [1:0] BE_CHAL    = 2'd3;

   // FSM state codes
   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_DECODE  = 3'd1;
   localparam state_t ST_ISSUE   = 3'd2;
   localparam state_t ST_WAIT_BE = 3'd3;
   localparam state_t ST_BUILD   = 3'd4;
   localparam state_t ST_SEND    = 3'd5;

   // Header / payload field positions
   localparam int HDR_VER_LSB  = 0;
   localparam int HDR_TYPE_LSB = 8;
   localparam int HDR_P1_LSB   = 16;
   localparam int HDR_P2_LSB   = 24;
   localparam int CERT_OFF_LSB = 32;
   localparam int CERT_LEN_LSB = 48;
   localparam int NONCE_LSB    = 32;
   localparam int NONCE_W      = 256;
   localparam int REQ_KEEP     = NONCE_LSB + NONCE_W;

   // Map a request message type onto the back-end command code.
   function automatic logic [1:0] be_type_of(input logic [7:0] mtype);
      logic [1:0] t;
      case (mtype)
         MT_GET_DIGESTS: t = BE_DIGESTS;
         MT_GET_CERT:    t = BE_CERT;
         MT_CHALLENGE:   t = BE_CHAL;
         default:        t = BE_NONE;
      endcase
      return t;
   endfunction

   // Header of an ERROR response: Param2 is always zero.
   function automatic logic [31:0] err_header(input logic [7:0] ver, input logic [7:0] code);
      return {8'h00, code, MT_ERROR, ver};
   endfunction

endpackage

// File: rtl/auth_timeout_ctr.sv
// Down-counter used as the back-end response-time budget. Load wins over
// decrement, srst clears it, and it saturates at zero instead of wrapping.
module auth_timeout_ctr
   import auth_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         srst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         expired
);

   logic [W-1:0] count_r;

   // Budget counter: clear, load, or count down toward zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_r <= {W{1'b0}};
      end else if (srst) begin
         count_r <= {W{1'b0}};
      end else if (load) begin
         count_r <= load_val;
      end else if (en && (count_r != {W{1'b0}})) begin
         count_r <= count_r - W'(1);
      end else begin
         count_r <= count_r;
      end
   end

   // The budget runs out on the decrement that takes the count to zero.
   always_comb begin
      expired = en && (count_r <= W'(1));
   end

endmodule

// File: rtl/auth_responder_p.sv
// USB Type-C authentication responder: decodes one request at a time,
// drives the credential/crypto back-end and returns a response or ERROR.
module auth_responder_p
   import auth_pkg::*;
#(
   parameter int                   MSG_W          = 1000,
   parameter int                   NUM_SLOTS      = 8,
   parameter logic [NUM_SLOTS-1:0] SLOT_MASK      = 8'h01,
   parameter int                   CERT_MAX_LEN   = 4096,
   parameter int                   DIGESTS_TO_CYC = 135000,
   parameter int                   CERT_TO_CYC    = 135000,
   parameter int                   CHAL_TO_CYC    = 635000,
   parameter logic [7:0]           PROTO_VER      = 8'h01
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [MSG_W-1:0]   req_msg,
   output logic               resp_valid,
   input  logic               resp_ready,
   output logic [MSG_W-1:0]   resp_msg,
   output logic               be_req,
   output logic [1:0]         be_type,
   output logic [7:0]         be_slot,
   output logic [15:0]        be_offset,
   output logic [15:0]        be_len,
   output logic [255:0]       be_nonce,
   input  logic               be_busy,
   input  logic               be_done,
   input  logic [MSG_W-33:0]  be_data,
   output logic               be_abort
);

   localparam int PW     = MSG_W - 32;
   localparam int MAX_A  = (DIGESTS_TO_CYC > CERT_TO_CYC) ? DIGESTS_TO_CYC : CERT_TO_CYC;
   localparam int MAX_TO = (MAX_A > CHAL_TO_CYC) ? MAX_A : CHAL_TO_CYC;
   localparam int TO_W   = $clog2(MAX_TO) + 1;

   state_t                state_r;
   logic [REQ_KEEP-1:0]   req_r;
   logic                  req_ready_r;
   logic                  resp_valid_r;
   logic [MSG_W-1:0]      resp_msg_r;
   logic                  be_req_r;
   logic [1:0]            be_type_r;
   logic [7:0]            be_slot_r;
   logic [15:0]           be_offset_r;
   logic [15:0]           be_len_r;
   logic [255:0]          be_nonce_r;
   logic                  be_abort_r;
   logic [PW-1:0]         be_data_r;

   logic [7:0]            ver_s, mtype_s, p1_s, p2_s;
   logic [15:0]           off_s, len_s;
   logic [16:0]           cert_sum_s;
   logic                  slot_ok_s;
   logic                  dec_err_s;
   logic [7:0]            dec_code_s;
   logic [TO_W-1:0]       budget_s;
   logic                  ctr_load_s, ctr_en_s, ctr_srst_s, ctr_expired_s;
   logic                  unused_req_s;

   // Only the header, certificate window and nonce are ever inspected.
   assign unused_req_s = ^req_msg[MSG_W-1:REQ_KEEP];

   assign ver_s   = req_r[HDR_VER_LSB  +: 8];
   assign mtype_s = req_r[HDR_TYPE_LSB +: 8];
   assign p1_s    = req_r[HDR_P1_LSB   +: 8];
   assign p2_s    = req_r[HDR_P2_LSB   +: 8];
   assign off_s   = req_r[CERT_OFF_LSB +: 16];
   assign len_s   = req_r[CERT_LEN_LSB +: 16];

   // Header validation in priority order; first failing check picks the code.
   always_comb begin
      slot_ok_s = 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         slot_ok_s = slot_ok_s | ((p1_s == 8'(i)) && SLOT_MASK[i]);
      end
      cert_sum_s = {1'b0, off_s} + {1'b0, len_s};
      dec_err_s  = 1'b0;
      dec_code_s = 8'h00;
      if (ver_s != PROTO_VER) begin
         dec_err_s  = 1'b1;
         dec_code_s = ERR_UNSUP_PROTO;
      end else if ((mtype_s != MT_GET_DIGESTS) && (mtype_s != MT_GET_CERT) &&
                   (mtype_s != MT_CHALLENGE)) begin
         dec_err_s  = 1'b1;
         dec_code_s = ERR_INVALID;
      end else if (((mtype_s == MT_GET_CERT) || (mtype_s == MT_CHALLENGE)) && !slot_ok_s) begin
         dec_err_s  = 1'b1;
         dec_code_s = ERR_INVALID;
      end else if ((mtype_s == MT_GET_CERT) &&
                   ((len_s == 16'd0) || (cert_sum_s > 17'(CERT_MAX_LEN)))) begin
         dec_err_s  = 1'b1;
         dec_code_s = ERR_INVALID;
      end else begin
         dec_err_s  = 1'b0;
         dec_code_s = 8'h00;
      end
   end

   // Per-request back-end budget and timeout counter controls.
   always_comb begin
      case (mtype_s)
         MT_GET_DIGESTS: budget_s = TO_W'(DIGESTS_TO_CYC);
         MT_GET_CERT:    budget_s = TO_W'(CERT_TO_CYC);
         MT_CHALLENGE:   budget_s = TO_W'(CHAL_TO_CYC);
         default:        budget_s = {TO_W{1'b0}};
      endcase
      ctr_load_s = (state_r == ST_DECODE) && !dec_err_s;
      ctr_en_s   = (state_r == ST_ISSUE) || (state_r == ST_WAIT_BE);
      ctr_srst_s = ((state_r == ST_ISSUE) && be_busy) ||
                   ((state_r == ST_WAIT_BE) && (be_done || ctr_expired_s));
   end

   auth_timeout_ctr #(.W(TO_W)) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .srst     (ctr_srst_s),
      .load     (ctr_load_s),
      .load_val (budget_s),
      .en       (ctr_en_s),
      .expired  (ctr_expired_s)
   );

   // Request/response FSM; all outputs are registered here.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= ST_IDLE;
         req_r        <= {REQ_KEEP{1'b0}};
         req_ready_r  <= 1'b1;
         resp_valid_r <= 1'b0;
         resp_msg_r   <= {MSG_W{1'b0}};
         be_req_r     <= 1'b0;
         be_type_r    <= BE_NONE;
         be_slot_r    <= 8'h00;
         be_offset_r  <= 16'h0000;
         be_len_r     <= 16'h0000;
         be_nonce_r   <= {256{1'b0}};
         be_abort_r   <= 1'b0;
         be_data_r    <= {PW{1'b0}};
      end else begin
         be_req_r   <= 1'b0;
         be_abort_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (req_valid && req_ready_r) begin
                  req_r       <= req_msg[REQ_KEEP-1:0];
                  req_ready_r <= 1'b0;
                  state_r     <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (dec_err_s) begin
                  resp_msg_r <= {{PW{1'b0}}, err_header(PROTO_VER, dec_code_s)};
                  state_r    <= ST_SEND;
               end else begin
                  be_req_r    <= 1'b1;
                  be_type_r   <= be_type_of(mtype_s);
                  be_slot_r   <= p1_s;
                  be_offset_r <= (mtype_s == MT_GET_CERT) ? off_s : 16'h0000;
                  be_len_r    <= (mtype_s == MT_GET_CERT) ? len_s : 16'h0000;
                  be_nonce_r  <= (mtype_s == MT_CHALLENGE) ? req_r[NONCE_LSB +: NONCE_W]
                                                           : {256{1'b0}};
                  state_r     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (be_busy) begin
                  resp_msg_r <= {{PW{1'b0}}, err_header(PROTO_VER, ERR_BUSY)};
                  state_r    <= ST_SEND;
               end else begin
                  state_r <= ST_WAIT_BE;
               end
            end
            ST_WAIT_BE: begin
               // A result arriving on the last budget cycle still counts.
               if (be_done) begin
                  be_data_r <= be_data;
                  state_r   <= ST_BUILD;
               end else if (ctr_expired_s) begin
                  be_abort_r <= 1'b1;
                  resp_msg_r <= {{PW{1'b0}}, err_header(PROTO_VER, ERR_UNSPEC)};
                  state_r    <= ST_SEND;
               end
            end
            ST_BUILD: begin
               resp_msg_r <= {be_data_r, p2_s, p1_s, mtype_s - MT_RESP_OFFSET, PROTO_VER};
               state_r    <= ST_SEND;
            end
            ST_SEND: begin
               if (!resp_valid_r) begin
                  resp_valid_r <= 1'b1;
               end else if (resp_ready) begin
                  resp_valid_r <= 1'b0;
                  req_ready_r  <= 1'b1;
                  state_r      <= ST_IDLE;
               end
            end
            default: begin
               resp_valid_r <= 1'b0;
               req_ready_r  <= 1'b1;
               state_r      <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_r;
   assign resp_valid = resp_valid_r;
   assign resp_msg   = resp_msg_r;
   assign be_req     = be_req_r;
   assign be_type    = be_type_r;
   assign be_slot    = be_slot_r;
   assign be_offset  = be_offset_r;
   assign be_len     = be_len_r;
   assign be_nonce   = be_nonce_r;
   assign be_abort   = be_abort_r;

endmodule

// File: doc/auth_responder_p.md
Name: auth_responder_p

Overview:
- Parametrised next-generation USB Type-C authentication responder.
- Accepts one authentication request message at a time and decodes its header.
- Services GET_DIGESTS, GET_CERTIFICATE and CHALLENGE through a credential/crypto back-end handshake, then emits a DIGESTS, CERTIFICATE, CHALLENGE_AUTH or ERROR response.
- Enforces per-request response-time budgets. Sits between the PD message layer (request/response ports) and the credential store / signing engine (back-end port).

Parameters:
MSG_W, 1000, request/response message width in bits (header in [31:0], payload above)
NUM_SLOTS, 8, certificate slots addressable by Param1
SLOT_MASK, 8'h01, provisioned-slot bitmap; bit i set means slot i usable
CERT_MAX_LEN, 4096, maximum certificate chain length in bytes
DIGESTS_TO_CYC, 135000, back-end budget in cycles for GET_DIGESTS
CERT_TO_CYC, 135000, back-end budget in cycles for GET_CERTIFICATE
CHAL_TO_CYC, 635000, back-end budget in cycles for CHALLENGE
PROTO_VER, 8'h01, only supported ProtocolVersion

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request message present
req_ready  out  1  responder can accept a request
req_msg  in  MSG_W  request message
resp_valid  out  1  response message present
resp_ready  in  1  consumer takes response
resp_msg  out  MSG_W  response message
be_req  out  1  back-end command strobe, one cycle
be_type  out  2  1=digests, 2=certificate, 3=challenge
be_slot  out  8  Param1 of the request
be_offset  out  16  certificate offset (bytes)
be_len  out  16  certificate length (bytes)
be_nonce  out  256  challenge nonce
be_busy  in  1  back-end busy; sampled in the cycle be_req is high
be_done  in  1  back-end result valid, one cycle
be_data  in  MSG_W-32  response payload
be_abort  out  1  one-cycle cancel on timeout

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; req_ready=1; resp_valid=0; resp_msg=0; be_req=0; be_abort=0; be_* payload outputs=0; timeout counter=0.
- Header fields: [7:0] ProtocolVersion, [15:8] MessageType, [23:16] Param1, [31:24] Param2.
- GET_CERTIFICATE payload: offset at [47:32], length at [63:48].
- CHALLENGE payload: nonce at [287:32].
- FSM states: IDLE, DECODE, ISSUE, WAIT_BE, BUILD, SEND.
- IDLE: req_ready=1. On req_valid&&req_ready, latch req_msg, go to DECODE; req_ready drops the next cycle.
- DECODE (1 cycle), checks in priority order:
  - ProtocolVersion!=PROTO_VER -> ERROR code 0x02 (UnsupportedProtocol).
  - MessageType not in {0x81,0x82,0x83} -> ERROR code 0x01 (InvalidRequest).
  - For 0x82/0x83: Param1>=NUM_SLOTS or SLOT_MASK[Param1]==0 -> ERROR 0x01.
  - For 0x82: length==0 or offset+length>CERT_MAX_LEN (17-bit sum) -> ERROR 0x01.
  - Otherwise go to ISSUE.
- ISSUE: be_req=1 for one cycle with operands; timeout counter loaded with the type's budget.
  - If be_busy=1 in that cycle -> ERROR 0x03 (Busy), no abort.
  - Else go to WAIT_BE.
- WAIT_BE: counter decrements each cycle.
  - be_done -> BUILD with payload latched.
  - Counter reaching 0 without be_done -> be_abort=1 for one cycle, ERROR 0x04 (Unspecified).
  - be_done in the same cycle the counter hits 0: be_done wins.
- BUILD (1 cycle): resp_msg = {be_data, Param2, Param1, respType, PROTO_VER}; respType = request type minus 0x80.
- ERROR responses: MessageType 0x7F, Param1=error code, Param2=0, payload 0. Built directly from DECODE/ISSUE/WAIT_BE, then SEND.
- SEND: resp_valid=1, resp_msg held stable until resp_ready. On handshake, return to IDLE next cycle with resp_valid=0.
- Latency from request accept to resp_valid:
  - Error from DECODE: 2 cycles.
  - Success: 4 + back-end latency cycles.
- Single outstanding request; no Busy error is generated for overlapping requests (req_ready=0 blocks them).
- be_done outside WAIT_BE is ignored.
- Timeout counter width is $clog2(max budget)+1; no wrap, it stops at 0.
- Reset mid-operation: everything returns to reset values immediately. No be_abort is issued; the back-end is reset by the same net.

Decomposition:
- Package auth_pkg:
  - request/response MessageType codes (0x81–0x83, 0x01–0x03, 0x7F);
  - error codes 0x01–0x04;
  - be_type encoding;
  - state enum;
  - header field bit positions.
- Sub-module auth_timeout_ctr: load/enable/expired interface, width parameter.

Test Plan:
- GET_DIGESTS (ver 0x01, type 0x81), be_done after 10 cycles with data 0xAB... -> resp type 0x01, payload 0xAB..., resp_valid 14 cycles after accept.
- GET_CERTIFICATE slot 0, offset 0, len 512 -> be_offset=0, be_len=512; slot 3 with SLOT_MASK=0x01 -> ERROR 0x7F/0x01, no be_req.
- ProtocolVersion 0x02 -> ERROR Param1=0x02; unknown type 0x90 -> ERROR Param1=0x01.
- CHALLENGE with be_done withheld (CHAL_TO_CYC=50 for sim) -> be_abort at cycle 50, ERROR Param1=0x04; a late be_done is ignored.
- be_busy=1 at issue -> ERROR Param1=0x03; resp_ready held low 20 cycles -> resp_msg stable, req_ready=0 throughout.
- Reset asserted in WAIT_BE -> req_ready=1, resp_valid=0, be_abort=0 immediately (asynchronous).
